// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD cost aligner: cost element types, the
// default geometry and the flush state encoding.
package sad_pkg;

  localparam int unsigned COST_WIDTH_DEF = 8;
  localparam int unsigned MAX_DISP_DEF   = 64;

  typedef logic [COST_WIDTH_DEF-1:0] cost_t;
  typedef cost_t [MAX_DISP_DEF-1:0]  cost_vec_t;

  localparam cost_t COST_PAD = '1;

  typedef enum logic {
    RUN,
    FLUSH
  } state_e;

endpackage

// File: rtl/sad_beat_history.sv
// Beat history shift register: slot 0 takes the load mux, older slots shift on en_i.
// All slots are exposed so the caller can read them diagonally.
module sad_beat_history
  import sad_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Slots = 3
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             en_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             load_real_i,
  input  logic             load_last_i,
  input  logic             load_user_i,
  output logic [Width-1:0] slot_data_o [Slots],
  output logic             slot_real_o [Slots],
  output logic             slot_last_o [Slots],
  output logic             slot_user_o [Slots]
);

  logic [Width-1:0] data_q [Slots];
  logic             real_q [Slots];
  logic             last_q [Slots];
  logic             user_q [Slots];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_q[0] <= '0;
      real_q[0] <= 1'b0;
      last_q[0] <= 1'b0;
      user_q[0] <= 1'b0;
    end else if (en_i) begin
      data_q[0] <= load_data_i;
      real_q[0] <= load_real_i;
      last_q[0] <= load_last_i;
      user_q[0] <= load_user_i;
    end
  end

  for (genvar i = 1; i < Slots; i++) begin : g_slot
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        data_q[i] <= '0;
        real_q[i] <= 1'b0;
        last_q[i] <= 1'b0;
        user_q[i] <= 1'b0;
      end else if (en_i) begin
        data_q[i] <= data_q[i-1];
        real_q[i] <= real_q[i-1];
        last_q[i] <= last_q[i-1];
        user_q[i] <= user_q[i-1];
      end
    end
  end

  assign slot_data_o = data_q;
  assign slot_real_o = real_q;
  assign slot_last_o = last_q;
  assign slot_user_o = user_q;

endmodule

// File: rtl/sad_cost_aligner.sv
// Aligns left-referenced SAD costs into left and right cost volumes on one AXI4-Stream
// master, flushing each line with all-ones pad beats so lines never mix.
module sad_cost_aligner
  import sad_pkg::*;
#(
  parameter int unsigned MAX_DISP   = MAX_DISP_DEF,
  parameter int unsigned SAMPLES    = 4,
  parameter int unsigned COST_WIDTH = COST_WIDTH_DEF
) (
  input  logic                                    aclk,
  input  logic                                    aresetn,
  input  logic [SAMPLES*MAX_DISP*COST_WIDTH-1:0]  s_axis_tdata,
  input  logic                                    s_axis_tvalid,
  output logic                                    s_axis_tready,
  input  logic                                    s_axis_tlast,
  input  logic                                    s_axis_tuser,
  output logic [SAMPLES*MAX_DISP*COST_WIDTH-1:0]  m_axis_tdata_l,
  output logic [SAMPLES*MAX_DISP*COST_WIDTH-1:0]  m_axis_tdata_r,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  output logic                                    m_axis_tuser
);

  localparam int unsigned L    = MAX_DISP / SAMPLES;
  localparam int unsigned W    = SAMPLES * MAX_DISP * COST_WIDTH;
  localparam int unsigned CntW = $clog2(L + 1);

  if ((MAX_DISP % SAMPLES) != 0) begin : g_disp_check
    $fatal(1, "MAX_DISP must be a multiple of SAMPLES");
  end
  if (SAMPLES < 1 || SAMPLES > 16) begin : g_samples_check
    $fatal(1, "SAMPLES must be in 1..16");
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
  logic            run_en_q;

  logic            out_free, in_hs, advance;
  logic [W-1:0]    load_data;
  logic            load_real, load_last, load_user;

  logic [W-1:0]    slot_data [L+1];
  logic            slot_real [L+1];
  logic            slot_last [L+1];
  logic            slot_user [L+1];
  logic [W-1:0]    post_data [L+1];
  logic [W-1:0]    right_d;

  logic            tvalid_q, tlast_q, tuser_q;
  logic [W-1:0]    tdata_l_q, tdata_r_q;

  assign out_free      = !tvalid_q || m_axis_tready;
  assign s_axis_tready = run_en_q && (state_q == RUN) && out_free;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign advance       = in_hs || ((state_q == FLUSH) && out_free);

  assign load_data = (state_q == FLUSH) ? '1 : s_axis_tdata;
  assign load_real = (state_q == RUN);
  assign load_last = (state_q == RUN) && s_axis_tlast;
  assign load_user = (state_q == RUN) && s_axis_tuser;

  sad_beat_history #(
    .Width (W),
    .Slots (L + 1)
  ) u_history (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .en_i        (advance),
    .load_data_i (load_data),
    .load_real_i (load_real),
    .load_last_i (load_last),
    .load_user_i (load_user),
    .slot_data_o (slot_data),
    .slot_real_o (slot_real),
    .slot_last_o (slot_last),
    .slot_user_o (slot_user)
  );

  // View of the history as it will look after this advance, so the output register
  // captures in the same edge the beat reaches slot L.
  assign post_data[0] = load_data;
  for (genvar i = 1; i <= L; i++) begin : g_post
    assign post_data[i] = slot_data[i-1];
  end

  // Pixel m+d lives (p+d)/P beats newer than slot L, in lane (p+d)%P.
  for (genvar p = 0; p < SAMPLES; p++) begin : g_lane
    for (genvar d = 0; d < MAX_DISP; d++) begin : g_disp
      localparam int unsigned SrcSlot = L - (p + d) / SAMPLES;
      localparam int unsigned SrcLane = (p + d) % SAMPLES;
      assign right_d[(p*MAX_DISP + d)*COST_WIDTH +: COST_WIDTH] =
          post_data[SrcSlot][(SrcLane*MAX_DISP + d)*COST_WIDTH +: COST_WIDTH];
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (in_hs && s_axis_tlast) begin
          state_d     = FLUSH;
          flush_cnt_d = CntW'(L);
        end
      end
      FLUSH: begin
        if (out_free) begin
          flush_cnt_d = flush_cnt_q - 1'b1;
          if (flush_cnt_q == CntW'(1)) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      run_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      run_en_q    <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      tdata_l_q <= '0;
      tdata_r_q <= '0;
    end else if (advance && slot_real[L-1]) begin
      tvalid_q  <= 1'b1;
      tlast_q   <= slot_last[L-1];
      tuser_q   <= slot_user[L-1];
      tdata_l_q <= post_data[L];
      tdata_r_q <= right_d;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tlast_q;
  assign m_axis_tuser   = tuser_q;
  assign m_axis_tdata_l = tdata_l_q;
  assign m_axis_tdata_r = tdata_r_q;

endmodule
